// File: rtl/mul_sequencer.sv
// Control FSM for the keypad multiplier: captures two signed-magnitude operands,
// launches the multiplier, waits under a timeout and selects what the display shows.
module mul_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  num_in,
    input  logic        sig_in,
    input  logic        load_pulse,
    input  logic        clear,
    input  logic        mul_done,
    input  logic [15:0] mul_product,
    input  logic        mul_sig,
    output logic [7:0]  op_a,
    output logic        sig_a,
    output logic [7:0]  op_b,
    output logic        sig_b,
    output logic        mul_start,
    output logic [15:0] disp_num,
    output logic        disp_sig,
    output logic        busy,
    output logic        error,
    output logic [2:0]  state_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_A = 3'd0,
        WAIT_B = 3'd1,
        START  = 3'd2,
        RUN    = 3'd3,
        SHOW   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      res;
    logic             res_sig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_A;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_A: if (load_pulse) state_nxt = WAIT_B;
            WAIT_B: if (load_pulse) state_nxt = START;
            START:  state_nxt = RUN;
            RUN: begin
                if (mul_done)             state_nxt = SHOW;
                else if (cnt == CNT_LAST) state_nxt = ERR;
            end
            SHOW:   if (load_pulse) state_nxt = WAIT_B;
            ERR:    state_nxt = ERR;
            default: state_nxt = WAIT_A;
        endcase
        if (clear) state_nxt = WAIT_A;
    end

    // Operand, result and timeout registers; clear has priority over every capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a    <= '0;
            sig_a   <= 1'b0;
            op_b    <= '0;
            sig_b   <= 1'b0;
            res     <= '0;
            res_sig <= 1'b0;
            cnt     <= '0;
        end else if (clear) begin
            op_a    <= '0;
            sig_a   <= 1'b0;
            op_b    <= '0;
            sig_b   <= 1'b0;
            res     <= '0;
            res_sig <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                WAIT_A, SHOW: begin
                    if (load_pulse) begin
                        op_a  <= num_in;
                        sig_a <= sig_in;
                    end
                end
                WAIT_B: begin
                    if (load_pulse) begin
                        op_b  <= num_in;
                        sig_b <= sig_in;
                    end
                end
                START: cnt <= '0;
                RUN: begin
                    // Leaves RUN at CNT_LAST at the latest, so the increment cannot wrap.
                    cnt <= cnt + 1'b1;
                    if (mul_done) begin
                        res     <= mul_product;
                        res_sig <= mul_sig & (mul_product != 16'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mul_start = (state == START);
        busy      = (state == START) || (state == RUN);
        error     = (state == ERR);
        state_o   = state;
        disp_num  = 16'd0;
        disp_sig  = 1'b0;
        case (state)
            WAIT_A, WAIT_B: begin
                disp_num = {8'd0, num_in};
                disp_sig = sig_in;
            end
            START, RUN: begin
                disp_num = {8'd0, op_b};
                disp_sig = sig_b;
            end
            SHOW: begin
                disp_num = res;
                disp_sig = res_sig;
            end
            default: ;
        endcase
    end

endmodule
